// File: rtl/mv_pkg.sv
// Shared types and constants for the motion-vector fetch sequencer.
// No logic; only parameters, widths and the controller state encoding.
package mv_pkg;

    localparam int BLOCKS_ROW_DFLT = 80;
    localparam int BLOCKS_COL_DFLT = 45;
    localparam int POS_W           = 7;
    localparam int MV_W            = 14;
    localparam int N_NORM          = 3;
    localparam int N_EXT           = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_CAPTURE,
        ST_PRESENT,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/mv_pos_counter.sv
// Raster x/y block counter with wrap at frame end and a last-block flag.
// Updates one cycle after adv/clr; clr wins over adv, no backpressure.
module mv_pos_counter
    import mv_pkg::*;
#(
    parameter int BLOCKS_ROW = BLOCKS_ROW_DFLT,
    parameter int BLOCKS_COL = BLOCKS_COL_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             adv,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             last
);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             row_end;

    assign row_end = (x_q == POS_W'(BLOCKS_ROW - 1));
    assign last    = row_end && (y_q == POS_W'(BLOCKS_COL - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (row_end) begin
                x_d = '0;
                y_d = last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/mv_fetch_sequencer.sv
// Walks every block of a frame: feeds the MV array, captures 3/4 candidates, waits for ME, writes back.
// Block period N+1+P+1 cycles; stalls in PRESENT until me_done, start ignored while busy.
module mv_fetch_sequencer
    import mv_pkg::*;
#(
    parameter int BLOCKS_ROW = BLOCKS_ROW_DFLT,
    parameter int BLOCKS_COL = BLOCKS_COL_DFLT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode_ext,
    input  logic            me_done,
    input  logic [MV_W-1:0] me_mv,
    input  logic [MV_W-1:0] vecout,
    output logic [MV_W-1:0] curpos,
    output logic            feed,
    output logic            extended,
    output logic            WE,
    output logic [MV_W-1:0] MVector,
    output logic [MV_W-1:0] cand0,
    output logic [MV_W-1:0] cand1,
    output logic [MV_W-1:0] cand2,
    output logic [MV_W-1:0] cand3,
    output logic            cand_valid,
    output logic            busy,
    output logic            frame_done
);

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic            ext_q, ext_d;
    logic            done_q, done_d;
    logic [MV_W-1:0] mvec_q, mvec_d;
    logic [MV_W-1:0] cand_q [4];
    logic [MV_W-1:0] cand_d [4];

    logic             pos_clr, pos_adv, pos_last;
    logic [POS_W-1:0] pos_x, pos_y;
    logic [1:0]       k_last;

    mv_pos_counter #(
        .BLOCKS_ROW (BLOCKS_ROW),
        .BLOCKS_COL (BLOCKS_COL)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .clr   (pos_clr),
        .adv   (pos_adv),
        .x     (pos_x),
        .y     (pos_y),
        .last  (pos_last)
    );

    assign k_last = ext_q ? 2'(N_EXT - 1) : 2'(N_NORM - 1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ext_d   = ext_q;
        done_d  = 1'b0;
        mvec_d  = mvec_q;
        cand_d  = cand_q;
        pos_clr = 1'b0;
        pos_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ext_d   = mode_ext;
                    pos_clr = 1'b1;
                    k_d     = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                // Read data trails the strobe by one cycle, so burst slot k lands data for k-1.
                if (k_q != 2'd0) begin
                    cand_d[k_q - 2'd1] = vecout;
                end
                if (k_q == k_last) begin
                    k_d     = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_CAPTURE: begin
                cand_d[k_last] = vecout;
                state_d        = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (me_done) begin
                    mvec_d  = me_mv;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pos_adv = 1'b1;
                k_d     = '0;
                if (pos_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FEED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ext_q   <= 1'b0;
            done_q  <= 1'b0;
            mvec_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cand_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ext_q   <= ext_d;
            done_q  <= done_d;
            mvec_q  <= mvec_d;
            cand_q  <= cand_d;
        end
    end

    // Strobes decode straight from state so reset drops them without waiting for an edge.
    assign feed       = (state_q == ST_FEED);
    assign WE         = (state_q == ST_WRITE);
    assign cand_valid = (state_q == ST_PRESENT);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign extended   = ext_q;
    assign MVector    = mvec_q;
    assign curpos     = {pos_y, pos_x};
    assign cand0      = cand_q[0];
    assign cand1      = cand_q[1];
    assign cand2      = cand_q[2];
    assign cand3      = ext_q ? cand_q[3] : '0;

endmodule

// File: tb/tb_mv_fetch_sequencer.sv
// Bench: behavioural MV array around the sequencer plus a block-level timing/content model.
// Drives randomized ME latency, results, and stray start/me_done noise over full frames.
module tb_mv_fetch_sequencer;
    import mv_pkg::*;

    localparam int ROW = 80;
    localparam int COL = 45;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mode_ext, me_done;
    logic [13:0] me_mv, vecout;
    logic [13:0] curpos, MVector, cand0, cand1, cand2, cand3;
    logic        feed, extended, WE, cand_valid, busy, frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mv_fetch_sequencer #(.BLOCKS_ROW(ROW), .BLOCKS_COL(COL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_ext   (mode_ext),
        .me_done    (me_done),
        .me_mv      (me_mv),
        .vecout     (vecout),
        .curpos     (curpos),
        .feed       (feed),
        .extended   (extended),
        .WE         (WE),
        .MVector    (MVector),
        .cand0      (cand0),
        .cand1      (cand1),
        .cand2      (cand2),
        .cand3      (cand3),
        .cand_valid (cand_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [13:0] init_val(int i);
        if (i == 0) return 14'h1234;
        if (i == 2) return 14'h0ABC;
        return 14'((i * 97 + 13) ^ (i >> 2));
    endfunction

    // Candidate k of block (x,y): left, up, right+2, up-right, each clamped to the frame.
    function automatic logic [13:0] nb_addr(logic [13:0] pos, logic [1:0] k);
        int x  = int'(pos[6:0]);
        int y  = int'(pos[13:7]);
        int nx = x;
        int ny = y;
        case (k)
            2'd0: nx = (x > 0) ? x - 1 : 0;
            2'd1: ny = (y > 0) ? y - 1 : 0;
            2'd2: nx = (x + 2 < ROW) ? x + 2 : ROW - 1;
            default: begin
                nx = (x + 1 < ROW) ? x + 1 : ROW - 1;
                ny = (y > 0) ? y - 1 : 0;
            end
        endcase
        return {7'(ny), 7'(nx)};
    endfunction

    // Array: feed counter shares the reset net; contents reload to a known picture on reset.
    logic [13:0] arr_mem [0:16383];
    logic [1:0]  arr_cnt;
    int          we_count = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            arr_cnt <= 2'd0;
            vecout  <= 14'd0;
            for (int i = 0; i < 16384; i++) arr_mem[i] <= init_val(i);
        end else begin
            if (feed) begin
                vecout  <= arr_mem[nb_addr(curpos, arr_cnt)];
                arr_cnt <= arr_cnt + 2'd1;
            end else if (!extended) begin
                arr_cnt <= 2'd0;
            end
            if (WE) begin
                arr_mem[curpos] <= MVector;
                we_count <= we_count + 1;
            end
        end
    end

    logic [13:0] ref_mem [0:16383];

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(string tag);
        chk({tag, "_feed"}, int'(feed), 0);
        chk({tag, "_we"}, int'(WE), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cv"}, int'(cand_valid), 0);
        chk({tag, "_curpos"}, int'(curpos), 0);
        chk({tag, "_ext"}, int'(extended), 0);
        chk({tag, "_mvec"}, int'(MVector), 0);
        chk({tag, "_c0"}, int'(cand0), 0);
        chk({tag, "_c1"}, int'(cand1), 0);
        chk({tag, "_c2"}, int'(cand2), 0);
        chk({tag, "_c3"}, int'(cand3), 0);
        chk({tag, "_fdone"}, int'(frame_done), 0);
    endtask

    // Expected outputs at cycle t of a block: N feeds, 1 capture, P present, 1 write.
    task automatic compare(int t, int n, int p, logic [13:0] pos, bit ext, logic [13:0] mv);
        logic [13:0] c [4];
        c[0] = cand0; c[1] = cand1; c[2] = cand2; c[3] = cand3;
        chk("feed", int'(feed), int'(t < n));
        chk("we", int'(WE), int'(t == n + p + 1));
        chk("cand_valid", int'(cand_valid), int'(t > n && t <= n + p));
        chk("busy", int'(busy), 1);
        chk("frame_done", int'(frame_done), 0);
        chk("extended", int'(extended), int'(ext));
        chk("curpos", int'(curpos), int'(pos));
        if (t > n && t <= n + p) begin
            for (int k = 0; k < n; k++)
                chk($sformatf("cand%0d", k), int'(c[k]), int'(ref_mem[nb_addr(pos, 2'(k))]));
            if (!ext) chk("cand3_zero", int'(cand3), 0);
        end
        if (t == n + 1) chk("arr_cnt_zero", int'(arr_cnt), 0);
        if (t == n + p + 1) chk("mvector", int'(MVector), int'(mv));
    endtask

    task automatic run_frame(bit ext, bit pin);
        int we0;
        chk("pre_start_busy", int'(busy), 0);
        start = 1'b1; mode_ext = ext; me_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        we0 = we_count;
        for (int by = 0; by < COL; by++) begin
            for (int bx = 0; bx < ROW; bx++) begin
                int          n   = ext ? 4 : 3;
                bit          pb  = pin && bx == 0 && by == 0;
                int          p   = pb ? 1 : $urandom_range(1, 2);
                logic [13:0] mv  = pb ? 14'h0155 : 14'($urandom);
                logic [13:0] pos = {7'(by), 7'(bx)};
                for (int t = 0; t <= n + p + 1; t++) begin
                    compare(t, n, p, pos, ext, mv);
                    if (pb && t == 4) begin
                        chk("lit_cv_c4", int'(cand_valid), 1);
                        chk("lit_c0", int'(cand0), 14'h1234);
                        chk("lit_c1", int'(cand1), 14'h1234);
                        chk("lit_c2", int'(cand2), 14'h0ABC);
                        chk("lit_c3", int'(cand3), 0);
                    end
                    if (pb && t == 5) begin
                        chk("lit_we_c5", int'(WE), 1);
                        chk("lit_mv", int'(MVector), 14'h0155);
                        chk("lit_pos", int'(curpos), 0);
                    end
                    if (pin && bx == 0 && by == 1 && t == 0)
                        chk("lit_row_wrap", int'(curpos), 14'h0080);
                    me_done  = (t == n + p) ? 1'b1 : (t <= n ? 1'($urandom_range(0, 1)) : 1'b0);
                    me_mv    = (t == n + p) ? mv : 14'($urandom);
                    start    = 1'($urandom_range(0, 1));
                    mode_ext = 1'($urandom_range(0, 1));
                    if (t == n + p + 1) ref_mem[pos] = mv;
                    @(negedge clk);
                end
            end
        end
        chk("fdone_pulse", int'(frame_done), 1);
        chk("fdone_busy", int'(busy), 0);
        chk("fdone_curpos", int'(curpos), 0);
        chk("fdone_feed", int'(feed), 0);
        chk("fdone_we", int'(WE), 0);
        chk("frame_we_count", we_count - we0, 3600);
        start = 1'b0; me_done = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
        reset = 1'b1; start = 1'b0; mode_ext = 1'b0; me_done = 1'b0; me_mv = 14'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst");

        // Abort a burst at k=1 with reset.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_feed_k0", int'(feed), 1);
        @(negedge clk);
        chk("mid_feed_k1", int'(feed), 1);
        reset = 1'b1;
        #1;
        chk("async_feed", int'(feed), 0);
        chk("async_we", int'(WE), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        chk_idle_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_curpos", int'(curpos), 0);

        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b0);
        @(negedge clk);
        chk("fdone_drop", int'(frame_done), 0);
        chk("stay_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
